// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a single-port word RAM with synchronous read.
// Sub-word stores are done as read-modify-write so the other byte lanes are preserved.
module mem_access_unit #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        req_err;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [15:0] wdata_q;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Picks the addressed lane out of a RAM word and extends it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wd,
                                             input logic [1:0] lo, input logic [1:0] size);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) r[{lo, 3'b000} +: 8] = wd[7:0];
    else               r[{lo[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  assign req_err = is_bad(req_size, req_addr[1:0]);
  assign accept  = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_wren   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                          state_next = RESP;
          else if (req_we && req_size == 2'b10) state_next = WR;
          else                                  state_next = RD_ADDR;
        end
      end
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = we_q ? WR : RESP;
      WR: begin
        ram_wren   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture: pure data, only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_q     <= req_addr[1:0];
      size_q   <= req_size;
      signed_q <= req_signed;
      we_q     <= req_we;
      wdata_q  <= req_wdata[15:0];
    end
  end

  // RAM drive and response registers; the address only moves when a RAM access is started.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        if (req_err) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end else begin
          ram_address <= req_addr[ADDR_W+1:2];
          if (req_we && req_size == 2'b10) ram_data <= req_wdata;
        end
      end
      if (state == RD_DATA) begin
        if (we_q) begin
          ram_data <= lane_merge(ram_q, wdata_q, lo_q, size_q);
        end else begin
          resp_rdata <= load_extract(ram_q, lo_q, size_q, signed_q);
          resp_err   <= 1'b0;
        end
      end
      if (state == WR) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a small word RAM, a shadow memory model with arithmetic lane rules,
// directed scenarios and randomized traffic.
module tb_mem_access_unit;
  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  logic [31:0]       ram_data;
  logic [31:0]       ram_q;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
  );

  // Synchronous-read word RAM, 16 words.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[3:0]] <= ram_data;
    ram_q <= mem[ram_address[3:0]];
  end

  int          wren_total = 0;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  always @(posedge clk) begin
    if (ram_wren) begin
      wren_total   <= wren_total + 1;
      last_wr_addr <= 32'(ram_address);
      last_wr_data <= ram_data;
    end
  end

  int          total = 0;
  int          passed = 0;
  logic [31:0] shadow [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input bit nowait,
                        output logic [31:0] got);
    int unsigned idx, lo, lat, cyc, n;
    int          snap;
    logic [31:0] word, v, mask, nw;
    logic        err, exp_w;
    if (!nowait) begin
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_addr = a; req_we = we; req_size = sz; req_signed = sg; req_wdata = wd;
    req_valid = 1'b1;

    idx = 32'(a[5:2]);
    lo  = 32'(a[1:0]);
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && lo != 0);
    v = 32'd0; nw = 32'd0; exp_w = 1'b0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat  = 3;
      word = shadow[idx];
      if (sz == 2'd2) v = word;
      else if (sz == 2'd0) begin
        v = (word >> (8 * lo)) & 32'hFF;
        if (sg && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else begin
        v = (word >> (16 * (lo / 2))) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v | 32'hFFFF0000;
      end
    end else begin
      lat   = (sz == 2'd2) ? 2 : 4;
      mask  = (sz == 2'd0) ? 32'hFF : ((sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF);
      nw    = (shadow[idx] & ~(mask << (8 * lo))) | ((wd & mask) << (8 * lo));
      shadow[idx] = nw;
      exp_w = 1'b1;
    end

    snap = wren_total;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("resp_latency", cyc, lat);
    check("resp_rdata", resp_rdata, v);
    check("resp_err", 32'(resp_err), 32'(err));
    check("wren_count", 32'(wren_total - snap), 32'(exp_w));
    if (exp_w) begin
      check("wr_addr", last_wr_addr, idx);
      check("wr_data", last_wr_data, nw);
    end
    got = resp_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] got, d;
    int          first, second, seen, snap, n;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_address", 32'(ram_address), 32'd0);
    check("rst_ram_data", ram_data, 32'd0);
    @(posedge clk);

    // Fill RAM with word stores; the first one is offered on the very first edge after reset.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = (i == 1) ? 32'h8899AABB : $urandom;
      do_req(32'(i * 4), 1'b1, 2'b10, 1'b0, d, (i == 0), got);
    end

    do_req(32'h4, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, got);
    check("ld_word_4", got, 32'h8899AABB);
    do_req(32'h7, 1'b0, 2'b00, 1'b1, 32'h0, 1'b0, got);
    check("ld_byte_7_s", got, 32'hFFFFFF88);
    do_req(32'h7, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, got);
    check("ld_byte_7_u", got, 32'h00000088);
    do_req(32'h6, 1'b0, 2'b01, 1'b1, 32'h0, 1'b0, got);
    check("ld_half_6_s", got, 32'hFFFF8899);
    do_req(32'h5, 1'b1, 2'b00, 1'b0, 32'hCAFE0011, 1'b0, got);
    check("st_byte_5_addr", last_wr_addr, 32'd1);
    check("st_byte_5_data", last_wr_data, 32'h889911BB);
    do_req(32'h3, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, got);
    do_req(32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, got);
    do_req(32'h2, 1'b1, 2'b10, 1'b0, 32'h12345678, 1'b0, got);

    for (int i = 0; i < 40; i++) begin
      do_req(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 1'b0, got);
    end

    // Two word loads with req_valid held high throughout.
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_addr = 32'h4; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    first = -1; second = -1; seen = 0;
    for (int k = 1; k <= 14; k++) begin
      #1;
      if (k == 5) req_valid = 1'b0;
      if (resp_valid) begin
        if (seen == 0) first = k;
        else if (seen == 1) second = k;
        seen++;
        check("b2b_rdata", resp_rdata, shadow[1]);
      end
      @(posedge clk);
    end
    check("b2b_first", 32'(first), 32'd3);
    check("b2b_second", 32'(second), 32'd7);
    check("b2b_count", 32'(seen), 32'd2);

    // Reset asserted while the word store sits in WR.
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_addr = 32'h8; req_we = 1'b1; req_size = 2'b10; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    snap = wren_total;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("wr_state_wren", 32'(ram_wren), 32'd1);
    check("wr_state_addr", 32'(ram_address), 32'd2);
    check("wr_state_data", ram_data, 32'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    check("rstwr_wren", 32'(ram_wren), 32'd0);
    check("rstwr_ready", 32'(req_ready), 32'd1);
    check("rstwr_resp_valid", 32'(resp_valid), 32'd0);
    check("rstwr_rdata", resp_rdata, 32'd0);
    check("rstwr_err", 32'(resp_err), 32'd0);
    check("rstwr_address", 32'(ram_address), 32'd0);
    check("rstwr_ram_data", ram_data, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rstwr_no_resp", 32'(resp_valid), 32'd0);
    end
    check("rstwr_no_write", 32'(wren_total - snap), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_req(32'h8, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, got);

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("ram_contents", mem[i], shadow[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
